alu_arbiter: RTL and testbench

Shares one alu instance between NUM_REQ requesters using round-robin arbitration. Each requester uses a valid/ready request channel and a single-cycle response pulse. The block captures the winning operands and drives one alu execute pulse. It then returns the registered alu result to the owning requester. It screens illegal opcodes and flags divide-by-zero, and sits between the requester-side fabric and the alu.

---
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one alu between NUM_REQ valid/ready requesters
module alu_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [3*NUM_REQ-1:0]            req_oper,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_a,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [2*DATA_WIDTH-1:0]         rsp_data,
    output logic                            rsp_err,
    output logic                            busy,
    output logic                            alu_execute,
    output logic [2:0]                      alu_oper,
    output logic [DATA_WIDTH-1:0]           alu_a,
    output logic [DATA_WIDTH-1:0]           alu_b,
    input  logic [2*DATA_WIDTH-1:0]         alu_res
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        rr_q, rr_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic [2:0]              oper_q, oper_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic                    alu_execute_q, alu_execute_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;

    logic                    found;
    logic [PTR_W-1:0]        win_idx;
    logic [PTR_W-1:0]        idx;
    logic [2:0]              win_oper;
    logic                    illegal;

    // Search upward from the rr pointer, wrapping; the first valid requester wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(rr_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    assign win_oper = req_oper[int'(win_idx)*3 +: 3];
    assign illegal  = (oper_q > 3'd4);

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        owner_d       = owner_q;
        oper_d        = oper_q;
        a_d           = a_q;
        b_d           = b_q;
        alu_execute_d = 1'b0;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        req_ready     = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[win_idx] = 1'b1;
                    owner_d = win_idx;
                    oper_d  = win_oper;
                    a_d     = req_a[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    b_d     = req_b[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    rr_d    = PTR_W'((int'(win_idx) + 1) % NUM_REQ);
                    // Illegal opcodes skip the alu entirely and answer from CAPT.
                    if (win_oper <= 3'd4) begin
                        state_d       = ISSUE;
                        alu_execute_d = 1'b1;
                    end else begin
                        state_d = CAPT;
                    end
                end
            end
            ISSUE: state_d = CAPT;
            CAPT: begin
                rsp_valid_d[owner_q] = 1'b1;
                if (illegal) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end else begin
                    rsp_data_d = alu_res;
                    rsp_err_d  = (oper_q == 3'd4) && (b_q == '0);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            owner_q       <= '0;
            oper_q        <= '0;
            a_q           <= '0;
            b_q           <= '0;
            alu_execute_q <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            owner_q       <= owner_d;
            oper_q        <= oper_d;
            a_q           <= a_d;
            b_q           <= b_d;
            alu_execute_q <= alu_execute_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign alu_execute = alu_execute_q;
    assign alu_oper    = oper_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed vector bench for alu_arbiter with a behavioural alu
module tb_alu_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [3*NR-1:0]   req_oper;
    logic [DW*NR-1:0]  req_a;
    logic [DW*NR-1:0]  req_b;
    logic [NR-1:0]     rsp_valid;
    logic [2*DW-1:0]   rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              alu_execute;
    logic [2:0]        alu_oper;
    logic [DW-1:0]     alu_a;
    logic [DW-1:0]     alu_b;
    logic [2*DW-1:0]   alu_res;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_oper(req_oper), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .alu_execute(alu_execute),
        .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res)
    );

    // Behavioural alu: result registered at the end of the execute cycle.
    always @(posedge clk) begin
        if (reset) alu_res <= '0;
        else if (alu_execute) begin
            case (alu_oper)
                3'd1: alu_res <= {8'h00, alu_a} + {8'h00, alu_b};
                3'd2: alu_res <= {8'h00, alu_a} - {8'h00, alu_b};
                3'd3: alu_res <= {8'h00, alu_a} * {8'h00, alu_b};
                3'd4: alu_res <= (alu_b == 0) ? 16'hDEAD : {8'h00, alu_a / alu_b};
                default: alu_res <= 16'h0000;
            endcase
        end
    end

    typedef struct {
        int         idx;
        logic [2:0] oper;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid[idx]        = 1'b1;
        req_oper[3*idx +: 3]  = op;
        req_a[DW*idx +: DW]   = a;
        req_b[DW*idx +: DW]   = b;
    endtask

    // Called just after the accepting edge; observes 8 cycles at the falling edge.
    task automatic wait_rsp(input string tag, input int idx, input int exp_lat,
                            input logic [15:0] exp_data, input logic exp_err, input int exp_exec);
        int got_lat = 0;
        int pulses  = 0;
        int execs   = 0;
        int exec_at = 0;
        logic [NR-1:0] vec = '0;
        logic [15:0]   dat = '0;
        logic          err = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (alu_execute) begin
                execs++;
                exec_at = cyc;
            end
            if (rsp_valid != 0) begin
                pulses++;
                if (got_lat == 0) begin
                    got_lat = cyc;
                    vec = rsp_valid;
                    dat = rsp_data;
                    err = rsp_err;
                end
            end
        end
        chk({tag, " latency"}, got_lat, exp_lat);
        chk({tag, " rsp_valid"}, {28'd0, vec}, 32'(1 << idx));
        chk({tag, " rsp_data"}, {16'd0, dat}, {16'd0, exp_data});
        chk({tag, " rsp_err"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, " pulses"}, pulses, 1);
        chk({tag, " exec count"}, execs, exp_exec);
        if (exp_exec == 1) chk({tag, " exec cycle"}, exec_at, 1);
        chk({tag, " data held"}, {16'd0, rsp_data}, {16'd0, exp_data});
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        set_req(v.idx, v.oper, v.a, v.b);
        #1;
        chk({tag, " ready"}, {28'd0, req_ready}, 32'(1 << v.idx));
        chk({tag, " idle busy"}, {31'd0, busy}, 0);
        @(posedge clk);
        #1;
        req_valid = '0;
        chk({tag, " busy"}, {31'd0, busy}, 1);
        chk({tag, " ready while busy"}, {28'd0, req_ready}, 0);
        wait_rsp(tag, v.idx, (v.oper > 4) ? 2 : 3, v.exp_data, v.exp_err, (v.oper > 4) ? 0 : 1);
    endtask

    initial begin
        int g;
        int r;
        int last_g;
        vecs[0] = '{0, 3'd1, 8'h12, 8'h34, 16'h0046, 1'b0};
        vecs[1] = '{2, 3'd4, 8'h50, 8'h00, 16'hDEAD, 1'b1};
        vecs[2] = '{2, 3'd4, 8'h50, 8'h05, 16'h0010, 1'b0};
        vecs[3] = '{1, 3'd6, 8'h11, 8'h22, 16'h0000, 1'b1};
        vecs[4] = '{3, 3'd2, 8'h03, 8'h05, 16'hFFFE, 1'b0};
        vecs[5] = '{0, 3'd3, 8'hFF, 8'hFF, 16'hFE01, 1'b0};
        vecs[6] = '{1, 3'd0, 8'h07, 8'h09, 16'h0000, 1'b0};
        vecs[7] = '{3, 3'd7, 8'h01, 8'h01, 16'h0000, 1'b1};
        vecs[8] = '{2, 3'd5, 8'h40, 8'h02, 16'h0000, 1'b1};

        reset = 1'b1;
        req_valid = '0;
        req_oper = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset rsp_valid", {28'd0, rsp_valid}, 0);
        chk("reset rsp_data", {16'd0, rsp_data}, 0);
        chk("reset rsp_err", {31'd0, rsp_err}, 0);
        chk("reset alu_execute", {31'd0, alu_execute}, 0);
        chk("reset alu_ops", {5'd0, alu_oper, 8'd0, alu_a, alu_b}, 0);
        chk("reset ready", {28'd0, req_ready}, 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            chk($sformatf("vec%0d alu_oper held", i), {29'd0, alu_oper}, {29'd0, vecs[i].oper});
            chk($sformatf("vec%0d alu_b held", i), {24'd0, alu_b}, {24'd0, vecs[i].b});
        end

        // Fairness: all requesters continuously valid from rr pointer 0.
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 3'd3, 8'(i + 1), 8'h10);
        g = 0;
        r = 0;
        last_g = 0;
        for (int cyc = 0; cyc < 30 && g < 5; cyc++) begin
            @(negedge clk);
            if (rsp_valid != 0) begin
                chk($sformatf("rr rsp%0d vec", r), {28'd0, rsp_valid}, 32'(1 << (r % NR)));
                chk($sformatf("rr rsp%0d data", r), {16'd0, rsp_data}, 32'(((r % NR) + 1) * 16));
                r++;
            end
            if (req_ready != 0) begin
                chk($sformatf("rr grant%0d", g), {28'd0, req_ready}, 32'(1 << (g % NR)));
                if (g > 0) chk($sformatf("rr gap%0d", g), cyc - last_g, 3);
                last_g = cyc;
                g++;
            end
        end
        chk("rr grants seen", g, 5);
        chk("rr responses seen", r, 4);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (6) @(posedge clk);
        #1;

        // Reset during ISSUE of a req0 op (leaves rr at 1 if reset were ignored).
        set_req(0, 3'd1, 8'h12, 8'h34);
        @(posedge clk);
        #1;
        req_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        chk("issue cycle execute", {31'd0, alu_execute}, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_req(1, 3'd1, 8'h01, 8'h01);
        set_req(0, 3'd1, 8'h12, 8'h34);
        @(negedge clk);
        chk("post-reset busy", {31'd0, busy}, 0);
        chk("post-reset rsp_valid", {28'd0, rsp_valid}, 0);
        chk("post-reset alu_execute", {31'd0, alu_execute}, 0);
        chk("post-reset alu_ops", {5'd0, alu_oper, 8'd0, alu_a, alu_b}, 0);
        chk("post-reset rsp_data", {15'd0, rsp_err, rsp_data}, 0);
        chk("post-reset rr pointer", {28'd0, req_ready}, 1);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_rsp("post-reset req0", 0, 3, 16'h0046, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
